// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, queue entry layout and slot-mask helper for the fetch front end.
package fetch_ctrl_pkg;

    localparam int unsigned BR_WD       = 33;
    localparam int unsigned FQ_ENTRY_WD = 98;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } fq_entry_t;

    // A fetch starting at the upper word of a packet only carries slot 1.
    function automatic logic [1:0] slot_mask(input logic [31:0] pc);
        return pc[2] ? 2'b10 : 2'b11;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue with synchronous flush and a registered head that holds its
// last value once the queue drains.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 98
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid;
    assign rd_next    = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Head reloads from the incoming word when the queue is (or becomes) empty
            // at that point, otherwise from the next stored entry; empty keeps the old value.
            if (!head_valid || (do_pop && count == CW'(1))) begin
                if (push) begin
                    head <= din;
                end
            end else if (do_pop) begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: 8-byte-aligned SRAM fetch with one-cycle latency, credit-based
// issue into a small packet queue, and branch-redirect flush.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [BR_WD-1:0] br_bus,
    input  logic             stall,
    output logic             inst_sram_en,
    output logic [31:0]      inst_sram_addr,
    input  logic [63:0]      inst_sram_rdata,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [63:0]      out_inst,
    output logic [1:0]       out_mask
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FQ_DEPTH);

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [1:0]  inflight_mask;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic        issue;
    logic        push;
    logic        pop;
    fq_entry_t   enq;
    fq_entry_t   head;

    assign {br_e, br_addr} = br_bus;

    // Credits cover both queued packets and the one still in the SRAM pipe;
    // resetn gating keeps the request low for the whole time reset is held.
    assign used         = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue        = resetn & ~br_e & (used < DEPTH_V);
    assign inst_sram_en = issue;
    assign inst_sram_addr = {fetch_pc[31:3], 3'b000};

    assign push = inflight & ~br_e;
    assign pop  = ~stall & ~br_e;
    assign enq  = '{pc: inflight_pc, inst: inst_sram_rdata, mask: inflight_mask};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            inflight_mask <= '0;
        end else begin
            inflight <= issue;
            if (br_e) begin
                fetch_pc <= {br_addr[31:2], 2'b00};
            end else if (issue) begin
                fetch_pc      <= {fetch_pc[31:3] + 29'd1, 3'b000};
                inflight_pc   <= {fetch_pc[31:3], 3'b000};
                inflight_mask <= slot_mask(fetch_pc);
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FQ_DEPTH),
        .WIDTH(FQ_ENTRY_WD)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (br_e),
        .push      (push),
        .pop       (pop),
        .din       (enq),
        .count     (count),
        .head_valid(out_valid),
        .head      (head)
    );

    assign out_pc   = head.pc;
    assign out_inst = head.inst;
    assign out_mask = head.mask;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every cycle, plus
// directed literal checks for reset, stall-fill, redirect, wrap and async reset.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        br_e = 1'b0;
    logic [31:0] br_addr = '0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [63:0] inst_sram_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [63:0] out_inst;
    logic [1:0]  out_mask;

    int n_cmp = 0;
    int n_fail = 0;

    fetch_ctrl #(
        .RESET_PC(RESET_PC),
        .FQ_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .br_bus         ({br_e, br_addr}),
        .stall          (stall),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_mask       (out_mask)
    );

    always #5 clk = ~clk;

    // SRAM returns the address pair as data; garbage when not read.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= {inst_sram_addr + 32'd4, inst_sram_addr};
        else
            inst_sram_rdata <= {$urandom(), $urandom()};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: PC, one in-flight read, a queue of packets and the last shown head.
    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  mask;
    } pkt_t;

    pkt_t        q[$];
    pkt_t        last;
    logic [31:0] m_pc = RESET_PC;
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [1:0]  m_infl_mask = '0;
    bit          exp_issue;

    task automatic model_reset();
        q.delete();
        last = '{32'h0, 64'h0, 2'b00};
        m_pc = RESET_PC;
        m_infl = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_sram_en", inst_sram_en, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_pc", out_pc, 0);
            check("rst_out_inst", out_inst, 0);
            check("rst_out_mask", out_mask, 0);
            model_reset();
        end else begin
            exp_issue = !br_e && (q.size() + int'(m_infl) < DEPTH);
            check("sram_en", inst_sram_en, exp_issue);
            check("sram_addr", inst_sram_addr, {m_pc[31:3], 3'b000});
            check("out_valid", out_valid, q.size() != 0);
            check("out_pc", out_pc, last.pc);
            check("out_inst", out_inst, last.inst);
            check("out_mask", out_mask, last.mask);
            if (br_e) begin
                q.delete();
            end else begin
                if (q.size() != 0 && !stall) void'(q.pop_front());
                if (m_infl) q.push_back('{m_infl_pc, inst_sram_rdata, m_infl_mask});
            end
            if (exp_issue) begin
                m_infl_pc   = {m_pc[31:3], 3'b000};
                m_infl_mask = m_pc[2] ? 2'b10 : 2'b11;
            end
            if (br_e) m_pc = {br_addr[31:2], 2'b00};
            else if (exp_issue) m_pc = {m_pc[31:3], 3'b000} + 32'd8;
            m_infl = exp_issue;
            if (q.size() != 0) last = q[0];
        end
    end

    task automatic drive(input bit b, input logic [31:0] a, input bit s);
        br_e = b;
        br_addr = a;
        stall = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("hold_rst_en", inst_sram_en, 0);
        check("hold_rst_valid", out_valid, 0);
        #1;
        resetn = 1'b1;

        // cycles 1..3 after release
        drive(0, 0, 0);
        check("c1_en", inst_sram_en, 1);
        check("c1_addr", inst_sram_addr, 32'hbfc0_0000);
        tick();
        drive(0, 0, 0);
        check("c2_addr", inst_sram_addr, 32'hbfc0_0008);
        check("c2_valid", out_valid, 0);
        tick();
        drive(0, 0, 1);
        check("c3_valid", out_valid, 1);
        check("c3_pc", out_pc, 32'hbfc0_0000);
        check("c3_mask", out_mask, 2'b11);
        check("c3_inst", out_inst, 64'hbfc0_0004_bfc0_0000);
        tick();
        drive(0, 0, 1); tick();
        drive(0, 0, 1); tick();
        drive(0, 0, 1);
        check("full_en", inst_sram_en, 0);
        check("full_pc", out_pc, 32'hbfc0_0000);
        tick();
        drive(0, 0, 0);
        check("full_en2", inst_sram_en, 0);
        tick();
        drive(0, 0, 0);
        check("resume_en", inst_sram_en, 1);
        check("resume_addr", inst_sram_addr, 32'hbfc0_0020);
        check("drain_pc1", out_pc, 32'hbfc0_0008);
        tick();
        drive(0, 0, 0);
        check("drain_pc2", out_pc, 32'hbfc0_0010);
        tick();
        drive(0, 0, 0);
        check("drain_pc3", out_pc, 32'hbfc0_0018);
        tick();
        drive(0, 0, 0);
        check("drain_pc4", out_pc, 32'hbfc0_0020);
        tick();

        // redirect into a full queue with stall held
        repeat (3) begin drive(0, 0, 1); tick(); end
        drive(1, 32'h8000_0104, 1);
        tick();
        drive(0, 0, 0);
        check("br_valid0", out_valid, 0);
        check("br_addr0", inst_sram_addr, 32'h8000_0100);
        check("br_en0", inst_sram_en, 1);
        tick();
        drive(0, 0, 0);
        check("br_addr1", inst_sram_addr, 32'h8000_0108);
        tick();
        drive(0, 0, 0);
        check("br_pkt0_pc", out_pc, 32'h8000_0100);
        check("br_pkt0_mask", out_mask, 2'b10);
        check("br_pkt0_valid", out_valid, 1);
        tick();
        drive(0, 0, 0);
        check("br_pkt1_pc", out_pc, 32'h8000_0108);
        check("br_pkt1_mask", out_mask, 2'b11);
        tick();

        // redirect with stall, then a second redirect two cycles later
        drive(1, 32'h9000_0000, 1); tick();
        drive(0, 0, 0); tick();
        drive(1, 32'h8000_0200, 0); tick();
        drive(0, 0, 0);
        check("bb_valid0", out_valid, 0);
        tick();
        drive(0, 0, 0);
        check("bb_valid1", out_valid, 0);
        tick();
        drive(0, 0, 0);
        check("bb_pc", out_pc, 32'h8000_0200);
        check("bb_mask", out_mask, 2'b11);
        tick();

        // wrap-around
        drive(1, 32'hffff_fff8, 0); tick();
        drive(0, 0, 0);
        check("wrap_addr0", inst_sram_addr, 32'hffff_fff8);
        tick();
        drive(0, 0, 0);
        check("wrap_addr1", inst_sram_addr, 32'h0000_0000);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        b;
            logic [31:0] a;
            b = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) a = 32'hffff_ffe0 + 32'($urandom_range(0, 31));
            else a = $urandom();
            drive(b, a, $urandom_range(0, 99) < 30);
            tick();
        end

        // async reset mid-stream
        repeat (5) begin drive(0, 0, 0); tick(); end
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_pc", out_pc, 0);
        check("arst_inst", out_inst, 0);
        check("arst_mask", out_mask, 0);
        check("arst_en", inst_sram_en, 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        drive(0, 0, 0);
        check("rst2_addr", inst_sram_addr, RESET_PC);
        check("rst2_en", inst_sram_en, 1);
        tick();
        drive(0, 0, 0); tick();
        drive(0, 0, 0);
        check("rst2_pc", out_pc, RESET_PC);
        check("rst2_valid", out_valid, 1);
        tick();
        repeat (3) begin drive(0, 0, 0); tick(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
